// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg: shared size/state encodings and the byte-enable helper
package data_mem_responder_pkg;
  typedef enum logic [1:0] {SIZE_B = 2'b00, SIZE_H = 2'b01, SIZE_W = 2'b10, SIZE_RSV = 2'b11} size_e;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_e;
  function automatic logic [3:0] byte_en(input logic [1:0] lane, input size_e sz);
    return sz == SIZE_B ? 4'b0001 << lane : sz == SIZE_H ? 4'b0011 << lane : 4'b1111;
  endfunction
endpackage

// File: rtl/mem_byte_lane.sv
// mem_byte_lane: byte-lane steering for one access; store merge, load extract/extend, misalignment
//   i_lane/i_size/i_unsigned describe the access, i_wdata is right-aligned store data, i_old the stored word;
//   o_wmerge is the word to write back, o_rdata the extended load value, o_misalign flags a bad lane for the size.
module mem_byte_lane
  import data_mem_responder_pkg::*;
(
  input  logic [1:0]  i_lane,
  input  size_e       i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_old,
  output logic [31:0] o_wmerge,
  output logic [31:0] o_rdata,
  output logic        o_misalign
);
  logic [3:0]  w_be;
  logic [31:0] w_wsh;
  logic [15:0] w_rsh;
  always_comb begin
    w_be = byte_en(i_lane, i_size);
    w_wsh = i_wdata << {i_lane, 3'b000};
    w_rsh = 16'(i_old >> {i_lane, 3'b000});
    o_wmerge = i_old;
    for (int b = 0; b < 4; b++) if (w_be[b]) o_wmerge[8*b +: 8] = w_wsh[8*b +: 8];
    o_rdata = i_size == SIZE_B ? {{24{w_rsh[7] & ~i_unsigned}}, w_rsh[7:0]} :
              i_size == SIZE_H ? {{16{w_rsh[15] & ~i_unsigned}}, w_rsh} : i_old;
    o_misalign = (i_size == SIZE_H && i_lane[0]) || (i_size == SIZE_W && i_lane != 2'b00);
  end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: word RAM serving byte/half/word loads and stores over valid/ready channels
//   request: i_req_valid/o_req_ready, i_req_we, i_req_addr (byte), i_req_size, i_req_unsigned, i_req_wdata
//   response: o_rsp_valid/i_rsp_ready, o_rsp_rdata (0 for stores and faults), o_rsp_err
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int    ADDR_W    = 7,
  parameter int    LATENCY   = 1,
  parameter string INIT_FILE = ""
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);
  state_e              r_state, w_state_nxt;
  logic [3:0]          r_cnt;
  logic                r_we, r_uns, r_err;
  size_e               r_size, w_req_size;
  logic [ADDR_W-1:0]   r_widx;
  logic [1:0]          r_lane;
  logic [31:0]         r_wdata, r_rdata, w_merge, w_ld;
  logic                w_idle, w_fault, w_misalign;
  logic [31:0]         r_mem [2**ADDR_W];
  assign w_idle = r_state == S_IDLE;
  assign w_req_size = size_e'(i_req_size);
  // Lane logic checks alignment of the incoming request while idle, and steers the captured one otherwise.
  mem_byte_lane u_lane (
    .i_lane     (w_idle ? i_req_addr[1:0] : r_lane),
    .i_size     (w_idle ? w_req_size : r_size),
    .i_unsigned (r_uns),
    .i_wdata    (r_wdata),
    .i_old      (r_mem[r_widx]),
    .o_wmerge   (w_merge),
    .o_rdata    (w_ld),
    .o_misalign (w_misalign)
  );
  assign w_fault = w_misalign || w_req_size == SIZE_RSV || i_req_addr[31:ADDR_W+2] != '0;
  assign o_req_ready = w_idle && !i_rst;
  assign o_rsp_valid = r_state == S_RESP;
  assign o_rsp_rdata = r_rdata;
  assign o_rsp_err = r_err;
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (i_req_valid) w_state_nxt = w_fault ? S_RESP : (LATENCY == 0 ? S_ACCESS : S_WAIT);
      S_WAIT:   if (r_cnt == 4'd0) w_state_nxt = S_ACCESS;
      S_ACCESS: w_state_nxt = S_RESP;
      S_RESP:   if (i_rsp_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_size  <= SIZE_B;
      r_widx  <= '0;
      r_lane  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: if (i_req_valid) begin
          r_we    <= i_req_we;
          r_uns   <= i_req_unsigned;
          r_size  <= w_req_size;
          r_widx  <= i_req_addr[ADDR_W+1:2];
          r_lane  <= i_req_addr[1:0];
          r_wdata <= i_req_wdata;
          r_cnt   <= 4'(LATENCY - 1);
          r_err   <= w_fault;
          r_rdata <= '0;
        end
        S_WAIT:   r_cnt <= r_cnt - 4'd1;
        S_ACCESS: r_rdata <= r_we ? '0 : w_ld;
        S_RESP: if (i_rsp_ready) begin
          r_err   <= 1'b0;
          r_rdata <= '0;
        end
        default: ;
      endcase
    end
  end
  // Array has no reset; a store commits only on its ACCESS edge, so reset during WAIT drops it.
  always @(posedge i_clk) begin
    if (r_state == S_ACCESS && r_we && !i_rst) r_mem[r_widx] <= w_merge;
  end
endmodule
